// File: rtl/x_uart_cmd_if.sv
// Byte/command bus between the UART receiver, the command decoder, the
// register file and the UART transmitter.
interface x_uart_cmd_if;
    logic       i_valid;
    logic [7:0] i_data;
    logic       o_wr;
    logic       o_rd;
    logic [6:0] o_addr;
    logic [7:0] o_wdata;
    logic       i_rvalid;
    logic [7:0] i_rdata;
    logic       o_tx_valid;
    logic [7:0] o_tx_data;
    logic       i_tx_ready;
    logic       o_busy;
    logic       o_err;

    // master: the command decoder; slave: receiver/register file/transmitter side
    modport master (
        input  i_valid, i_data, i_rvalid, i_rdata, i_tx_ready,
        output o_wr, o_rd, o_addr, o_wdata, o_tx_valid, o_tx_data, o_busy, o_err
    );

    modport slave (
        output i_valid, i_data, i_rvalid, i_rdata, i_tx_ready,
        input  o_wr, o_rd, o_addr, o_wdata, o_tx_valid, o_tx_data, o_busy, o_err
    );
endinterface

// File: rtl/x_uart_cmd.sv
// UART byte-stream command decoder: 2-byte writes, 1-byte reads with the
// read response returned to the transmitter, plus timeout and drop detection.
module x_uart_cmd #(
    parameter int p_timeout = 120000
) (
    input  logic          i_clk,
    input  logic          i_rst,
    x_uart_cmd_if.master  bus
);
    localparam int                lp_tw   = $clog2(p_timeout);
    localparam logic [lp_tw-1:0]  lp_tmax = lp_tw'(p_timeout - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WDATA,
        ST_WRITE,
        ST_READ,
        ST_RWAIT,
        ST_TX
    } state_t;

    state_t             state_reg, state_next;
    logic [lp_tw-1:0]   timer_reg, timer_next;
    logic [6:0]         addr_reg, addr_next;
    logic [7:0]         wdata_reg, wdata_next;
    logic [7:0]         tx_data_reg, tx_data_next;
    logic               err_reg, err_next;
    logic               expired;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg   <= ST_IDLE;
            timer_reg   <= '0;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            tx_data_reg <= '0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            timer_reg   <= timer_next;
            addr_reg    <= addr_next;
            wdata_reg   <= wdata_next;
            tx_data_reg <= tx_data_next;
            err_reg     <= err_next;
        end
    end

    assign expired = (timer_reg == lp_tmax);

    always_comb begin
        state_next   = state_reg;
        addr_next    = addr_reg;
        wdata_next   = wdata_reg;
        tx_data_next = tx_data_reg;
        err_next     = 1'b0;
        // Timer runs only while waiting; every other state parks it at zero,
        // so entry into WDATA/RWAIT always starts from a cleared count.
        if (state_reg == ST_WDATA || state_reg == ST_RWAIT)
            timer_next = timer_reg + lp_tw'(1);
        else
            timer_next = '0;

        case (state_reg)
            ST_IDLE: begin
                if (bus.i_valid) begin
                    addr_next  = bus.i_data[6:0];
                    state_next = bus.i_data[7] ? ST_WDATA : ST_READ;
                end
            end
            ST_WDATA: begin
                if (bus.i_valid) begin
                    wdata_next = bus.i_data;
                    state_next = ST_WRITE;
                end else if (expired) begin
                    err_next   = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_WRITE: begin
                err_next   = bus.i_valid;
                state_next = ST_IDLE;
            end
            ST_READ: begin
                err_next   = bus.i_valid;
                state_next = ST_RWAIT;
            end
            ST_RWAIT: begin
                err_next = bus.i_valid;
                // A response arriving on the expiry cycle still wins.
                if (bus.i_rvalid) begin
                    tx_data_next = bus.i_rdata;
                    state_next   = ST_TX;
                end else if (expired) begin
                    err_next   = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_TX: begin
                err_next = bus.i_valid;
                if (bus.i_tx_ready)
                    state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign bus.o_wr       = (state_reg == ST_WRITE);
    assign bus.o_rd       = (state_reg == ST_READ);
    assign bus.o_tx_valid = (state_reg == ST_TX);
    assign bus.o_busy     = (state_reg != ST_IDLE);
    assign bus.o_addr     = addr_reg;
    assign bus.o_wdata    = wdata_reg;
    assign bus.o_tx_data  = tx_data_reg;
    assign bus.o_err      = err_reg;
endmodule

// File: tb/tb_x_uart_cmd.sv
// Randomized transaction-level bench for x_uart_cmd with a small outcome model.
module tb_x_uart_cmd;
    localparam int lp_to = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    x_uart_cmd_if bus();

    x_uart_cmd #(.p_timeout(lp_to)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor: counts events seen on the bus, sampled on the falling edge.
    int         cyc = 0;
    int         wr_cnt = 0, rd_cnt = 0, err_cnt = 0, busy_cnt = 0, tx_cnt = 0, tx_bad = 0;
    int         wr_cyc = 0, rd_cyc = 0, tx_start_cyc = 0;
    logic [6:0] last_wr_addr = '0, last_rd_addr = '0;
    logic [7:0] last_wr_data = '0, last_tx_data = '0;
    logic       prev_txv = 1'b0;
    logic [7:0] exp_tx = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.o_wr) begin
                wr_cnt <= wr_cnt + 1; wr_cyc <= cyc;
                last_wr_addr <= bus.o_addr; last_wr_data <= bus.o_wdata;
            end
            if (bus.o_rd) begin
                rd_cnt <= rd_cnt + 1; rd_cyc <= cyc; last_rd_addr <= bus.o_addr;
            end
            if (bus.o_err)  err_cnt  <= err_cnt + 1;
            if (bus.o_busy) busy_cnt <= busy_cnt + 1;
            if (bus.o_tx_valid) begin
                if (!prev_txv) tx_start_cyc <= cyc;
                if (bus.o_tx_data !== exp_tx) tx_bad <= tx_bad + 1;
                if (bus.i_tx_ready) begin
                    tx_cnt <= tx_cnt + 1; last_tx_data <= bus.o_tx_data;
                end
            end
        end
        prev_txv <= bus.o_tx_valid;
    end

    // Model state: values the held outputs must show between commands.
    logic [7:0] m_wdata = '0;
    logic [7:0] m_tx    = '0;

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        forever begin
            @(negedge clk); #2;
            if (!bus.o_busy) break;
            n++;
            if (n > 60) begin
                check("idle_timeout", 32'(n), 32'd0);
                break;
            end
        end
    endtask

    task automatic do_write(input logic [6:0] a, input logic [7:0] d, input int g, input bit to);
        int wr0 = wr_cnt, rd0 = rd_cnt, er0 = err_cnt, bz0 = busy_cnt;
        int dc = 0;
        bus.i_data = {1'b1, a}; bus.i_valid = 1'b1;
        tick();
        bus.i_valid = 1'b0;
        if (!to) begin
            repeat (g) tick();
            bus.i_data = d; bus.i_valid = 1'b1; dc = cyc;
            tick();
            bus.i_valid = 1'b0;
            m_wdata = d;
        end
        wait_idle();
        $display("write addr=%02h data=%02h gap=%0d timeout=%0d", a, d, g, to);
        check("wr_count", 32'(wr_cnt - wr0), to ? 32'd0 : 32'd1);
        check("wr_rd_count", 32'(rd_cnt - rd0), 32'd0);
        check("wr_err", 32'(err_cnt - er0), to ? 32'd1 : 32'd0);
        check("wr_busy_cycles", 32'(busy_cnt - bz0), to ? 32'(lp_to) : 32'(g + 2));
        check("wr_addr_held", 32'(bus.o_addr), 32'(a));
        check("wr_wdata_held", 32'(bus.o_wdata), 32'(m_wdata));
        if (!to) begin
            check("wr_addr", 32'(last_wr_addr), 32'(a));
            check("wr_data", 32'(last_wr_data), 32'(d));
            check("wr_latency", 32'(wr_cyc), 32'(dc + 1));
        end
    endtask

    task automatic do_read(input logic [6:0] a, input logic [7:0] d, input int k, input bit to,
                           input int s, input bit drop, input bit junk);
        int wr0 = wr_cnt, rd0 = rd_cnt, er0 = err_cnt, bz0 = busy_cnt, tx0 = tx_cnt, bad0 = tx_bad;
        int c0, r0 = 0;
        bit dropped = 0;
        exp_tx = d;
        bus.i_data = {1'b0, a}; bus.i_valid = 1'b1; c0 = cyc;
        tick();
        bus.i_valid = 1'b0;
        // Response presented alongside o_rd must be ignored.
        if (junk) begin
            bus.i_rdata = ~d; bus.i_rvalid = 1'b1;
        end
        tick();
        bus.i_rvalid = 1'b0;
        if (!to) begin
            repeat (k) tick();
            bus.i_rdata = d; bus.i_rvalid = 1'b1; r0 = cyc;
            tick();
            bus.i_rvalid = 1'b0;
            for (int i = 0; i < s; i++) begin
                if (drop && i == 0 && s >= 2) begin
                    bus.i_data = 8'h99; bus.i_valid = 1'b1; dropped = 1;
                end
                tick();
                bus.i_valid = 1'b0;
            end
            bus.i_tx_ready = 1'b1;
            tick();
            bus.i_tx_ready = 1'b0;
            m_tx = d;
        end
        wait_idle();
        $display("read addr=%02h data=%02h delay=%0d timeout=%0d stall=%0d drop=%0d junk=%0d",
                 a, d, k, to, s, dropped, junk);
        check("rd_count", 32'(rd_cnt - rd0), 32'd1);
        check("rd_addr", 32'(last_rd_addr), 32'(a));
        check("rd_latency", 32'(rd_cyc), 32'(c0 + 1));
        check("rd_wr_count", 32'(wr_cnt - wr0), 32'd0);
        check("rd_tx_count", 32'(tx_cnt - tx0), to ? 32'd0 : 32'd1);
        check("rd_err", 32'(err_cnt - er0), 32'(int'(to) + int'(dropped)));
        check("rd_busy_cycles", 32'(busy_cnt - bz0), to ? 32'(lp_to + 1) : 32'(k + s + 3));
        check("rd_tx_data_held", 32'(bus.o_tx_data), 32'(m_tx));
        check("rd_addr_held", 32'(bus.o_addr), 32'(a));
        if (!to) begin
            check("tx_data", 32'(last_tx_data), 32'(d));
            check("tx_latency", 32'(tx_start_cyc), 32'(r0 + 1));
            check("tx_stable", 32'(tx_bad - bad0), 32'd0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wr"},       32'(bus.o_wr),       32'd0);
        check({tag, "_rd"},       32'(bus.o_rd),       32'd0);
        check({tag, "_addr"},     32'(bus.o_addr),     32'd0);
        check({tag, "_wdata"},    32'(bus.o_wdata),    32'd0);
        check({tag, "_tx_valid"}, 32'(bus.o_tx_valid), 32'd0);
        check({tag, "_tx_data"},  32'(bus.o_tx_data),  32'd0);
        check({tag, "_busy"},     32'(bus.o_busy),     32'd0);
        check({tag, "_err"},      32'(bus.o_err),      32'd0);
    endtask

    initial begin
        bus.i_valid = 1'b0; bus.i_data = '0; bus.i_rvalid = 1'b0;
        bus.i_rdata = '0; bus.i_tx_ready = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk); #2;

        // Directed scenarios
        do_write(7'h05, 8'h3C, 0, 0);
        do_read(7'h12, 8'hA7, 2, 0, 5, 0, 0);
        do_write(7'h01, 8'h00, 0, 1);
        do_write(7'h01, 8'h55, 0, 0);
        do_read(7'h33, 8'h5A, 0, 0, 4, 1, 0);
        do_write(7'h7F, 8'hC3, lp_to - 1, 0);
        do_read(7'h44, 8'h81, lp_to - 1, 0, 0, 0, 1);
        do_read(7'h45, 8'h00, 0, 1, 0, 0, 0);

        // Randomized command stream
        for (int t = 0; t < 40; t++) begin
            int kind = $urandom_range(0, 5);
            logic [6:0] a = 7'($urandom);
            logic [7:0] d = 8'($urandom);
            int g = ($urandom_range(0, 3) == 0) ? lp_to - 1 : $urandom_range(0, lp_to - 1);
            case (kind)
                0, 1: do_write(a, d, g, 0);
                2:    do_write(a, d, 0, 1);
                3, 4: do_read(a, d, g, 0, $urandom_range(0, 6), 1'($urandom), 1'($urandom));
                default: do_read(a, d, 0, 1, 0, 0, 1'($urandom));
            endcase
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk); #2;
            end
        end

        // Reset while waiting for a read response
        bus.i_data = 8'h12; bus.i_valid = 1'b1;
        tick();
        bus.i_valid = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        $display("reset during read wait");
        check_reset_outputs("midrst");
        bus.i_rdata = 8'hA7; bus.i_rvalid = 1'b1;
        tick();
        bus.i_rvalid = 1'b0;
        tick();
        check("late_rvalid_tx_valid", 32'(bus.o_tx_valid), 32'd0);
        check("late_rvalid_busy", 32'(bus.o_busy), 32'd0);
        check("late_rvalid_tx_data", 32'(bus.o_tx_data), 32'd0);
        m_wdata = '0; m_tx = '0;
        @(negedge clk); #2;
        do_write(7'h22, 8'h66, 3, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
